// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the counter sequencer: FSM encoding, prescaler floor
// and step synchronizer depth.
package counter_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MIN_PERIOD  = 2;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/counter_ctrl_edge_sync.sv
// Brings the raw step button into clk and emits a registered one-cycle pulse
// on each synchronized rising edge.
module edge_sync
    import counter_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer driving the lab up-counter's inc input from a programmable rate or
// a step button, stopping once the fed-back count reaches limit.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] period,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count,
    output logic             inc,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] last_div;
    logic             step_rise;
    logic             at_limit;
    logic             tick;

    edge_sync u_step_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (step),
        .rise   (step_rise)
    );

    assign at_limit = (count == limit);
    // >= rather than == so a live shrink of period below div still fires.
    assign last_div = (period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD - 1)
                                                    : period - DIV_W'(1);
    assign tick     = (div >= last_div);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            div   <= '0;
            inc   <= 1'b0;
        end else begin
            inc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (at_limit) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            div   <= '0;
                        end
                    end else if (step_rise && !at_limit) begin
                        inc <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (!at_limit) begin
                            inc <= 1'b1;
                            div <= '0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized bench for counter_ctrl with a schedule-based reference model and
// a behavioural 8-bit up-counter closing the count feedback loop.
module tb_counter_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        step;
    logic [15:0] period;
    logic [7:0]  limit;
    logic [7:0]  count = 8'd0;
    logic        inc;
    logic        busy;
    logic        done;
    logic        load_en;
    logic [7:0]  load_val;

    int total = 0;
    int bad   = 0;

    counter_ctrl #(.WIDTH(8), .DIV_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .stop   (stop),
        .step   (step),
        .period (period),
        .limit  (limit),
        .count  (count),
        .inc    (inc),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Lab counter with a bench-side preload.
    always @(posedge clk) begin
        if (load_en) count <= load_val;
        else if (inc) count <= count + 8'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic load_count(input int c0, input int p, input int lim);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = 8'(c0);
        period   = 16'(p);
        limit    = 8'(lim);
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Pulses land at 1+m*P after start is sampled; DONE one period after the last.
    task automatic run_txn(input int c0, input int n, input int p, input int stop_at,
                           input bit stay_done, output bit ended_done);
        int pe, end_j, pulses;
        bit e_inc, e_busy, e_done;
        pe     = (p < 2) ? 2 : p;
        end_j  = (n == 0) ? 1 : 1 + (n + 1) * pe;
        pulses = 0;
        load_count(c0, p, (c0 + n) & 255);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= end_j + 2; j++) begin
            if (stop_at > 0 && j > stop_at) begin
                e_inc = 0; e_busy = 0; e_done = 0;
            end else begin
                e_done = (j >= end_j);
                e_busy = !e_done;
                e_inc  = (n > 0) && (j > 1) && ((j - 1) % pe == 0) && ((j - 1) / pe <= n);
            end
            pulses += int'(e_inc);
            check_val("run_inc", inc, e_inc);
            check_val("run_busy", busy, e_busy);
            check_val("run_done", done, e_done);
            stop = (j == stop_at);
            @(negedge clk);
        end
        stop = 1'b0;
        check_val("run_count", count, (c0 + pulses) & 255);
        ended_done = (stop_at == 0);
        if (ended_done && !stay_done) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check_val("done_exit", done, 0);
            check_val("exit_busy", busy, 0);
        end
        $display("run c0=%0d n=%0d period=%0d stop_at=%0d pulses=%0d", c0, n, p, stop_at, pulses);
    endtask

    // Each separated step rise driven at j yields one pulse seen at j+4.
    task automatic step_txn(input int hi, input int lo, input int hi2, input bit at_lim);
        int c0, r2, pulses;
        bit e_inc;
        c0     = int'($urandom_range(0, 100));
        r2     = hi + lo;
        pulses = 0;
        load_count(c0, 4, at_lim ? c0 : c0 + 100);
        for (int j = 0; j <= r2 + hi2 + 6; j++) begin
            if (j > 0) begin
                e_inc = !at_lim && (j == 4 || j == r2 + 4);
                pulses += int'(e_inc);
                check_val("step_inc", inc, e_inc);
            end
            step = (j < hi) || (j >= r2 && j < r2 + hi2);
            @(negedge clk);
        end
        step = 1'b0;
        repeat (6) @(negedge clk);
        check_val("step_count", count, (c0 + pulses) & 255);
        check_val("step_busy", busy, 0);
        $display("step hi=%0d lo=%0d hi2=%0d at_limit=%0d pulses=%0d", hi, lo, hi2, at_lim, pulses);
    endtask

    initial begin
        bit ended;
        int n, p, pe, end_j, s;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        period = 16'd4; limit = 8'd0; load_en = 1'b0; load_val = 8'd0;
        repeat (2) @(negedge clk);
        check_val("rst_inc", inc, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        resetn = 1'b1;
        @(negedge clk);

        run_txn(0, 3, 4, 0, 0, ended);      // basic run
        run_txn(254, 3, 0, 0, 0, ended);    // clamp + wrap to limit 1
        step_txn(10, 3, 4, 0);
        step_txn(10, 3, 4, 1);
        run_txn(0, 3, 6, 6, 0, ended);      // stop on the tick cycle

        // start with stop from IDLE
        load_count(5, 3, 9);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (4) begin
            check_val("ss_busy", busy, 0);
            check_val("ss_inc", inc, 0);
            @(negedge clk);
        end
        $display("start+stop together from IDLE");

        // asynchronous reset while inc is high
        load_count(0, 3, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_inc", inc, 1);
        #1 resetn = 1'b0;
        #1;
        check_val("arst_inc", inc, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_val("post_rst_inc", inc, 0);
            check_val("post_rst_busy", busy, 0);
        end
        $display("reset mid-run");

        // DONE ignores start and step, leaves on stop
        run_txn(10, 2, 3, 0, 1, ended);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("dn_start_done", done, 1);
        check_val("dn_start_busy", busy, 0);
        step = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_val("dn_step_inc", inc, 0);
            check_val("dn_step_done", done, 1);
        end
        step = 1'b0;
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("dn_stop_done", done, 0);
        check_val("dn_stop_busy", busy, 0);
        $display("done exit");

        for (int i = 0; i < 20; i++) begin
            n     = int'($urandom_range(0, 4));
            p     = int'($urandom_range(0, 5));
            pe    = (p < 2) ? 2 : p;
            end_j = (n == 0) ? 1 : 1 + (n + 1) * pe;
            s     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, end_j)) : 0;
            run_txn(int'($urandom_range(0, 255)), n, p, s, 0, ended);
        end
        for (int i = 0; i < 4; i++) begin
            step_txn(int'($urandom_range(2, 8)), int'($urandom_range(2, 6)),
                     int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer for the lab 8-bit up-counter (`clk`, `resetn`, `inc`, `count`). It drives the counter's `inc` input from one of two sources: a programmable free-running rate (RUN mode) or a debounce-free single-step button (STEP). It stops automatically when the counter's `count` reaches a programmed limit. It sits between the board-level controls and the counter, and it reads `count` back to decide when to stop.

## Interface
- `WIDTH`, default 8: counter width; must match the counter instance.
- `DIV_W`, default 16: width of the rate prescaler and the `period` input.

- `clk`  in  1: single system clock; all state changes on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: synchronous one-cycle request to begin auto-counting.
- `stop`  in  1: synchronous one-cycle request to abort RUN or to clear DONE.
- `step`  in  1: raw, asynchronous button level; each rising edge requests one increment.
- `period`  in  DIV_W: clock cycles between auto increments; values 0 and 1 are treated as 2.
- `limit`  in  WIDTH: target count; reaching it ends RUN.
- `count`  in  WIDTH: registered count fed back from the counter.
- `inc`  out  1: registered one-cycle increment pulse to the counter.
- `busy`  out  1: high while in RUN.
- `done`  out  1: high while in DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start` with `count == limit` goes straight to DONE.
  - `start` otherwise goes to RUN and clears the prescaler `div`.
  - A synchronized `step` rising edge pulses `inc` once, unless `count == limit`. The state stays IDLE.
- **RUN**
  - `div` increments every cycle.
  - When `div == P-1`, where `P = max(period, 2)`:
    - if `count != limit`: set `inc <= 1` and `div <= 0`;
    - otherwise go to DONE with no pulse.
  - `step` edges are ignored.
  - `period` is sampled live. If `div >= P-1` after a change, the next cycle fires a tick.
- **DONE**
  - `inc` stays 0 and `done` stays 1.
  - `stop` goes to IDLE. `start` and `step` are ignored.
- Priority when events coincide:
  - `stop` beats `start`.
  - `stop` beats a tick in the same cycle: no pulse is issued and the state goes to IDLE.
  - `stop` in IDLE is a no-op.
- Wrap-around: no special handling. The counter wraps 255→0, and RUN continues until `count == limit`. Example: count 254, limit 1 takes 3 pulses.
- `inc` is never high on two consecutive cycles. The minimum `P` of 2 guarantees `count` has updated before the next limit compare.

## Timing
- Reset values: `inc=0`, `busy=0`, `done=0`, state IDLE, `div=0`, synchronizer flops 0.
- Asserting `resetn` low mid-RUN immediately forces all of the above. No pulse follows reset release until a new `start` or step edge.
- `start` sampled at edge 0 gives RUN and `busy=1` after edge 1.
- The first `inc` goes high after edge `1+P`. Subsequent pulses are exactly `P` cycles apart.
- `inc` is high for exactly one cycle. The counter updates `count` at the edge that ends that cycle.
- DONE entry: the tick evaluation that sees `count == limit` sets `done=1` and `busy=0` at that edge.
- `step`: 2-flop synchronizer plus a registered edge detect. A level rising before edge k gives `inc` high after edge k+3.
- Pulses are spaced as follows:
  - a step held high produces one pulse;
  - edges closer than 2 cycles apart may merge;
  - each separated edge yields exactly one pulse.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - `MIN_PERIOD = 2`;
  - the synchronizer depth `SYNC_STAGES = 2`.
- Sub-module `edge_sync`: synchronizer plus rising-edge detector. Inputs `clk`, `resetn`, `d`; output `rise`, one cycle wide.
- The top level contains the FSM, the prescaler and the limit compare.
- The prescaler and FSM use the same asynchronous reset.

## Test plan
1. **Basic RUN.** Reset with count=0, `period=4`, `limit=3`, then pulse `start`.
   - Required: three `inc` pulses 4 cycles apart, the first 5 cycles after `start`.
   - At the 4th tick: `done=1`, `busy=0`, count=3, no 4th pulse.
2. **Period clamp and wrap.** `period=0`, count=254, `limit=1`, then `start`.
   - Required: pulses every 2 cycles, count 255→0→1, then DONE.
   - `inc` is never high on two consecutive cycles.
3. **Step.** In IDLE, raise `step` for 10 cycles, drop it, and raise it again.
   - Required: exactly two pulses, each 3 edges after the rise.
   - With `count == limit`, a step edge gives no pulse.
4. **Stop mid-RUN.** `period=6`; assert `stop` on the same cycle `div == 5`.
   - Required: no pulse, IDLE next cycle, `busy=0`.
   - `start` and `stop` asserted together from IDLE leave the state in IDLE.
5. **Reset mid-RUN.** Assert `resetn` low asynchronously between edges.
   - Required: `inc`, `busy` and `done` all go to 0 immediately.
   - After release: no pulses for 20 cycles without `start`.
6. **DONE exit.** In DONE, pulse `start`, then `step`, then `stop`.
   - Required: `start` and `step` are ignored, `done` stays 1, and IDLE follows the cycle after `stop`.
